// File: rtl/deal_ctrl.sv
// Game-round controller: deals four LFSR cards, keeps a BCD round count and a
// BCD countdown, and packs twelve display digits. Optional timer: DEAL_TIMER_EN.
module deal_ctrl #(
    parameter logic [15:0] SEED          = 16'h0001,
    parameter int          TICKS_PER_SEC = 100_000_000,
    parameter logic [7:0]  TIME_LIMIT    = 8'h60
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        deal,
    input  logic        solved,
    output logic [47:0] numbers_concat,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [1:0] {S_IDLE, S_DEAL, S_PLAY, S_OVER} state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic [3:0]  w_cand;
    logic        w_valid;
    logic [7:0]  w_cand_bcd;
    logic [1:0]  r_cnt;
    logic [7:0]  r_pend [0:2];
    logic [31:0] r_hand;
    logic [7:0]  r_round, w_round_inc;
    logic        r_playing;
    logic        w_accept, w_publish, w_solve, w_restart;
    logic        w_expire;
    logic [7:0]  w_secs;

    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand     = r_lfsr[3:0];
    assign w_valid    = (w_cand != 4'd0) && (w_cand <= 4'd13);
    assign w_cand_bcd = (w_cand >= 4'd10) ? {4'h1, w_cand - 4'd10} : {4'h0, w_cand};

    assign w_round_inc = (r_round[3:0] == 4'd9) ?
                         {((r_round[7:4] == 4'd9) ? 4'd0 : r_round[7:4] + 4'd1), 4'd0} :
                         {r_round[7:4], r_round[3:0] + 4'd1};

`ifdef DEAL_TIMER_EN
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_secs, w_secs_dec;
    logic          w_tick;
    logic          r_game_over;

    assign w_tick     = (r_state == S_PLAY) && (r_presc == PRESC_MAX);
    assign w_secs_dec = (r_secs[3:0] == 4'd0) ? {r_secs[7:4] - 4'd1, 4'd9}
                                              : {r_secs[7:4], r_secs[3:0] - 4'd1};
    assign w_expire   = w_tick && (w_secs_dec == 8'h00);
    assign w_secs     = r_secs;
    assign game_over  = r_game_over;

    // Timer only runs in PLAY; it is frozen (at 00) in OVER and held in DEAL.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            r_presc     <= '0;
            r_secs      <= 8'h00;
            r_game_over <= 1'b0;
        end else begin
            r_game_over <= (w_state_next == S_OVER);
            if (w_publish) begin
                r_presc <= '0;
                r_secs  <= TIME_LIMIT;
            end else if (r_state == S_PLAY) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick)
                    r_secs <= w_secs_dec;
            end
        end
    end
`else
    assign w_expire  = 1'b0;
    assign w_secs    = 8'h00;
    assign game_over = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_publish    = 1'b0;
        w_solve      = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            S_IDLE: if (deal) w_state_next = S_DEAL;
            S_DEAL: begin
                if (w_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_publish    = 1'b1;
                        w_state_next = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                // A player action takes precedence over a coincident timeout.
                if (solved) begin
                    w_solve      = 1'b1;
                    w_state_next = S_DEAL;
                end else if (deal) begin
                    w_state_next = S_DEAL;
                end else if (w_expire) begin
                    w_state_next = S_OVER;
                end
            end
            S_OVER: begin
                if (deal) begin
                    w_restart    = 1'b1;
                    w_state_next = S_DEAL;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= SEED;
            r_cnt     <= 2'd0;
            r_hand    <= 32'h0;
            r_round   <= 8'h00;
            r_playing <= 1'b0;
            for (int i = 0; i < 3; i++)
                r_pend[i] <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_lfsr    <= {r_lfsr[14:0], w_fb};
            r_playing <= (w_state_next == S_PLAY);
            // First three cards wait in r_pend so the hand changes in one step.
            if (w_accept) begin
                if (w_publish) begin
                    r_hand <= {r_pend[0], r_pend[1], r_pend[2], w_cand_bcd};
                    r_cnt  <= 2'd0;
                end else begin
                    r_pend[r_cnt] <= w_cand_bcd;
                    r_cnt         <= r_cnt + 2'd1;
                end
            end
            if (w_solve)
                r_round <= w_round_inc;
            else if (w_restart)
                r_round <= 8'h00;
        end
    end

    assign numbers_concat = {r_hand, r_round, w_secs};
    assign playing        = r_playing;

endmodule
